// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } arb_state_t;

  // Owner encoding, also the bit position of each requester in req[1:0]
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  // Beat counter width; bounds MAX_BURST to 1..15
  localparam int BEAT_CNT_W = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: sole requester wins, a tie goes to the one that did not own last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is acted upon.
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       any
);

  // DMA wins when it is alone, or on a tie when the CPU owned last
  always_comb begin
    any    = |req;
    winner = OWNER_CPU;
    if (req[1] && (!req[0] || (last_owner == OWNER_CPU))) begin
      winner = OWNER_DMA;
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Arbitrates CPU and DMA access to a single-port data memory with bounded round-robin bursts.
// Latency: grant is combinational from req while owning; read data returns 1 cycle after the granted beat.
// Backpressure: a requester holds req until gnt; the waiting side is stalled at most MAX_BURST beats.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [BEAT_CNT_W-1:0] BURST_LIM = BEAT_CNT_W'(MAX_BURST);

  arb_state_t            state;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [BEAT_CNT_W-1:0] beat_nxt;
  logic                  burst_done;
  logic                  last_owner;
  logic                  rr_winner;
  logic                  rr_any;
  logic                  own_req;
  logic                  oth_req;
  logic                  oth_owner;
  arb_state_t            oth_state;

  arb_rr2 u_rr (
    .req        ({dma_req, cpu_req}),
    .last_owner (last_owner),
    .winner     (rr_winner),
    .any        (rr_any)
  );

  // Grants follow the owner's req directly; the memory port is zeroed when nobody is granted
  always_comb begin
    cpu_gnt   = (state == OWN_CPU) && cpu_req;
    dma_gnt   = (state == OWN_DMA) && dma_req;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Current owner's view of the requests, so both OWN states share one set of transition rules
  always_comb begin
    own_req    = (state == OWN_DMA) ? dma_req : cpu_req;
    oth_req    = (state == OWN_DMA) ? cpu_req : dma_req;
    oth_owner  = (state == OWN_DMA) ? OWNER_CPU : OWNER_DMA;
    oth_state  = (state == OWN_DMA) ? OWN_CPU : OWN_DMA;
    beat_nxt   = beat_cnt + 1'b1;
    burst_done = (beat_nxt == BURST_LIM);
  end

  // Ownership FSM with beat counter and last-owner record; counter clears on every state change
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_owner <= OWNER_DMA;
    end else begin
      case (state)
        IDLE: begin
          if (rr_any) begin
            state      <= (rr_winner == OWNER_DMA) ? OWN_DMA : OWN_CPU;
            last_owner <= rr_winner;
            beat_cnt   <= '0;
          end
        end
        OWN_CPU, OWN_DMA: begin
          if (!own_req) begin
            beat_cnt <= '0;
            if (oth_req) begin
              state      <= oth_state;
              last_owner <= oth_owner;
            end else begin
              state <= IDLE;
            end
          end else if (burst_done) begin
            // Burst limit hit: hand over if the other side waits, else keep going from zero
            beat_cnt <= '0;
            if (oth_req) begin
              state      <= oth_state;
              last_owner <= oth_owner;
            end
          end else begin
            beat_cnt <= beat_nxt;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Read return: register memory data on each granted read beat; rdata holds otherwise
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dma_rvalid <= dma_gnt && !dma_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata <= mem_rdata;
      end
      if (dma_gnt && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb with a small behavioural memory behind the arbiter.
// Latency: checks sampled on the falling edge, inputs driven 1 ns after the rising edge.
// Backpressure: requests are held or dropped explicitly by each step.
module tb_dmem_arb;

  logic        clk = 1'b0;
  logic        clrn;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];

  int checks = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dmem_arb #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Combinational-read, edge-write memory
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hA5A5A5A5;
    mem[8'h20] = 32'h12345678;
    idle_inputs();
    clrn = 1'b0;

    // Reset state
    #2;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    next_cycle();
    next_cycle();

    // Single CPU read from IDLE: 1 idle cycle, grant, then data
    clrn = 1'b1;
    cpu_req = 1; cpu_addr = 32'h10;
    settle();
    chk("s1_idle_gnt", cpu_gnt, 0);
    next_cycle(); settle();
    chk("s1_cpu_gnt", cpu_gnt, 1);
    chk("s1_mem_addr", mem_addr, 32'h10);
    chk("s1_mem_we_read", mem_we, 0);
    next_cycle();
    cpu_req = 0; settle();
    chk("s1_rvalid", cpu_rvalid, 1);
    chk("s1_rdata", cpu_rdata, 32'hA5A5A5A5);
    chk("s1_gnt_drop", cpu_gnt, 0);
    chk("s1_addr_zero", mem_addr, 0);
    next_cycle(); settle();
    chk("s1_rvalid_one_cycle", cpu_rvalid, 0);
    chk("s1_rdata_hold", cpu_rdata, 32'hA5A5A5A5);

    // Fresh reset, then a tie: CPU gets exactly 4 beats, DMA follows with no gap
    next_cycle();
    clrn = 1'b0; #1; clrn = 1'b1;
    cpu_req = 1; cpu_addr = 32'h10;
    dma_req = 1; dma_addr = 32'h20;
    settle();
    chk("s2_idle_cpu", cpu_gnt, 0);
    chk("s2_idle_dma", dma_gnt, 0);
    for (int b = 0; b < 4; b++) begin
      next_cycle(); settle();
      chk($sformatf("s2_cpu_beat%0d", b), cpu_gnt, 1);
      chk($sformatf("s2_dma_wait%0d", b), dma_gnt, 0);
      if (b > 0) chk($sformatf("s2_cpu_rv%0d", b), cpu_rvalid, 1);
    end
    next_cycle(); settle();
    chk("s2_dma_gnt", dma_gnt, 1);
    chk("s2_cpu_off", cpu_gnt, 0);
    chk("s2_cpu_last_rv", cpu_rvalid, 1);
    chk("s2_dma_addr", mem_addr, 32'h20);
    next_cycle();
    idle_inputs(); settle();
    chk("s2_dma_rvalid", dma_rvalid, 1);
    chk("s2_dma_rdata", dma_rdata, 32'h12345678);
    chk("s2_cpu_rv_end", cpu_rvalid, 0);

    // DMA write then CPU read of the same word
    next_cycle();
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hDEADBEEF;
    settle();
    chk("s3_idle_we", mem_we, 0);
    next_cycle(); settle();
    chk("s3_dma_gnt", dma_gnt, 1);
    chk("s3_mem_we", mem_we, 1);
    chk("s3_mem_addr", mem_addr, 32'h20);
    chk("s3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    cpu_req = 1; cpu_addr = 32'h20;
    settle();
    chk("s3_we_pulse_end", mem_we, 0);
    chk("s3_no_dma_rv_a", dma_rvalid, 0);
    next_cycle(); settle();
    chk("s3_cpu_gnt", cpu_gnt, 1);
    chk("s3_no_dma_rv_b", dma_rvalid, 0);
    next_cycle();
    cpu_req = 0; settle();
    chk("s3_cpu_rvalid", cpu_rvalid, 1);
    chk("s3_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("s3_no_dma_rv_c", dma_rvalid, 0);

    // CPU alone for 10 beats: counter wraps without breaking the grant stream
    next_cycle();
    cpu_req = 1; cpu_addr = 32'h10;
    settle();
    chk("s4_idle", cpu_gnt, 0);
    for (int b = 0; b < 10; b++) begin
      next_cycle(); settle();
      chk($sformatf("s4_beat%0d", b), cpu_gnt, 1);
      if (b > 0) chk($sformatf("s4_rv%0d", b), cpu_rvalid, 1);
    end
    next_cycle();
    cpu_req = 0; settle();
    chk("s4_tail_rv", cpu_rvalid, 1);
    chk("s4_tail_gnt", cpu_gnt, 0);

    // DMA read burst interrupted by a reset pulse; the next tie goes to the CPU
    next_cycle();
    dma_req = 1; dma_we = 0; dma_addr = 32'h10;
    settle();
    chk("s5_idle", dma_gnt, 0);
    next_cycle(); settle();
    chk("s5_dma_beat0", dma_gnt, 1);
    next_cycle(); settle();
    chk("s5_dma_beat1", dma_gnt, 1);
    chk("s5_dma_rv_before", dma_rvalid, 1);
    next_cycle();
    clrn = 1'b0; #1;
    chk("s5_rst_dma_gnt", dma_gnt, 0);
    chk("s5_rst_mem_we", mem_we, 0);
    chk("s5_rst_mem_addr", mem_addr, 0);
    chk("s5_rst_dma_rv", dma_rvalid, 0);
    clrn = 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    settle();
    chk("s5_post_idle_gnt", dma_gnt, 0);
    chk("s5_post_dma_rv", dma_rvalid, 0);
    next_cycle(); settle();
    chk("s5_tie_cpu", cpu_gnt, 1);
    chk("s5_tie_dma", dma_gnt, 0);
    chk("s5_post_dma_rv2", dma_rvalid, 0);

    // CPU drops req mid-burst with DMA waiting: DMA granted the following cycle
    next_cycle(); settle();
    chk("s6_cpu_beat1", cpu_gnt, 1);
    next_cycle();
    cpu_req = 0; settle();
    chk("s6_drop_cpu", cpu_gnt, 0);
    chk("s6_drop_dma", dma_gnt, 0);
    next_cycle(); settle();
    chk("s6_dma_gnt", dma_gnt, 1);
    chk("s6_dma_addr", mem_addr, 32'h10);
    next_cycle();
    idle_inputs(); settle();
    chk("s6_dma_rdata", dma_rdata, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
